pc_gen: RTL and testbench

- Parametrised fetch-address generator for the pipelined RISC-V core; successor to the single-width, always-advancing program counter.
- Adds:
  - fetch valid/ready handshake (stall)
  - prioritised redirect sources: trap, then branch/jump
  - boot/halt state machine
  - target-misalignment detection
- Sits between hazard/EX/CSR logic and instruction memory; its output address drives the I-side.

---
 rtl/pc_pkg.sv | 7 +
 rtl/pc_next_sel.sv | 44 ++++
 rtl/pc_gen.sv | 70 +++++++
 tb/tb_pc_gen.sv | 93 +++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared states, default vectors and redirect-priority select for pc_gen.
package pc_pkg;
  typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_t;
  typedef enum logic [2:0] {SEL_TRAP, SEL_MISALIGN, SEL_REDIRECT, SEL_STEP, SEL_HOLD} pc_sel_t;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: prioritised next-pc mux with redirect alignment check.
// PC_GEN_RVC_EN selects 2/4-byte stepping and halfword alignment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(PC_TRAP_VEC_DEF),
  parameter int STEP = 4
) (
  input  logic            active,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  input  logic            pc_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
`ifdef PC_GEN_RVC_EN
  input  logic            fetch_is_c,
`endif
  output logic [XLEN-1:0] pc_next,
  output logic            misalign,
  output pc_sel_t         sel
);
  logic            bad_align;
  logic [XLEN-1:0] step;
  always_comb begin
`ifdef PC_GEN_RVC_EN
    bad_align = redirect_addr[0];
    step      = fetch_is_c ? XLEN'(2) : XLEN'(4);
`else
    bad_align = |redirect_addr[1:0];
    step      = XLEN'(STEP);
`endif
    sel = !active                  ? SEL_HOLD :
          trap_valid               ? SEL_TRAP :
          redirect_valid && bad_align ? SEL_MISALIGN :
          redirect_valid           ? SEL_REDIRECT :
          pc_valid && pc_ready     ? SEL_STEP : SEL_HOLD;
    pc_next = (sel == SEL_TRAP || sel == SEL_MISALIGN) ? TRAP_VEC :
              sel == SEL_REDIRECT ? redirect_addr :
              sel == SEL_STEP     ? pc + step : pc;
    misalign = sel == SEL_MISALIGN;
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator with stall handshake, trap/redirect priority and boot/halt FSM.
// Optional compressed-instruction stepping via PC_GEN_RVC_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC_DEF),
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
`ifdef PC_GEN_RVC_EN
  input  logic            fetch_is_c,
`endif
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            halted
);
  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  pc_sel_t         sel;
  pc_next_sel #(.XLEN(XLEN), .TRAP_VEC(TRAP_VEC), .STEP(STEP)) u_sel (
    .active         (state_q != PC_BOOT),
    .pc             (pc_q),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_valid     (trap_valid),
`ifdef PC_GEN_RVC_EN
    .fetch_is_c     (fetch_is_c),
`endif
    .pc_next        (pc_d),
    .misalign       (err_d),
    .sel            (sel)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN:  state_d = (halt_req && !trap_valid && !redirect_valid) ? PC_HALT : PC_RUN;
      PC_HALT: state_d = resume ? PC_RUN : PC_HALT;
      default: state_d = PC_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VEC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end
  assign pc           = pc_q;
  assign pc_valid     = state_q == PC_RUN;
  assign halted       = state_q == PC_HALT;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of pc_gen in its default build (RVC disabled).
module tb_pc_gen;
  logic        clk = 0, reset = 1, pc_ready = 0, redirect_valid = 0, trap_valid = 0;
  logic        halt_req = 0, resume = 0;
  logic [31:0] redirect_addr = 0;
  logic [31:0] pc;
  logic        pc_valid, misalign_err, halted;
  int checks = 0, errors = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .pc_ready(pc_ready), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .trap_valid(trap_valid), .halt_req(halt_req),
    .resume(resume), .pc(pc), .pc_valid(pc_valid), .misalign_err(misalign_err),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                         input logic eerr, input logic eh);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".valid"}, 32'(pc_valid), 32'(ev));
    chk({tag, ".err"}, 32'(misalign_err), 32'(eerr));
    chk({tag, ".halted"}, 32'(halted), 32'(eh));
  endtask

  initial begin
    pc_ready = 1;
    tick(); tick();
    chk_all("reset", 32'h0, 0, 0, 0);
    reset = 0;
    #1 chk_all("boot", 32'h0, 0, 0, 0);
    tick(); chk_all("run0", 32'h0, 1, 0, 0);
    tick(); chk_all("run4", 32'h4, 1, 0, 0);
    tick(); chk_all("run8", 32'h8, 1, 0, 0);
    pc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("stall8", 32'h8, 1, 0, 0);
    end
    pc_ready = 1;
    tick(); chk_all("run12", 32'hC, 1, 0, 0);
    tick(); chk_all("run16", 32'h10, 1, 0, 0);
    pc_ready = 0; redirect_valid = 1; redirect_addr = 32'h40; trap_valid = 1;
    tick(); chk_all("trap_wins", 32'h100, 1, 0, 0);
    trap_valid = 0;
    tick(); chk_all("redir40", 32'h40, 1, 0, 0);
    redirect_addr = 32'h42;
    tick(); chk_all("misalign", 32'h100, 1, 1, 0);
    redirect_valid = 0;
    tick(); chk_all("misalign_pulse", 32'h100, 1, 0, 0);
    redirect_valid = 1; redirect_addr = 32'h20;
    tick(); chk_all("redir20", 32'h20, 1, 0, 0);
    redirect_valid = 0; halt_req = 1; trap_valid = 1;
    tick(); chk_all("trap_vs_halt", 32'h100, 1, 0, 0);
    trap_valid = 0; halt_req = 0; redirect_valid = 1; redirect_addr = 32'h20;
    tick(); chk_all("redir20b", 32'h20, 1, 0, 0);
    redirect_valid = 0; halt_req = 1;
    tick(); chk_all("halt", 32'h20, 0, 0, 1);
    redirect_valid = 1; redirect_addr = 32'h80;
    tick(); chk_all("halt_redir", 32'h80, 0, 0, 1);
    redirect_valid = 0; pc_ready = 1;
    tick(); chk_all("halt_hold", 32'h80, 0, 0, 1);
    halt_req = 0; pc_ready = 0; resume = 1;
    tick(); chk_all("resume", 32'h80, 1, 0, 0);
    resume = 0; halt_req = 1;
    tick(); chk_all("halt2", 32'h80, 0, 0, 1);
    halt_req = 0; reset = 1; redirect_valid = 1; redirect_addr = 32'h43;
    tick(); chk_all("reset_halted", 32'h0, 0, 0, 0);
    reset = 0; redirect_addr = 32'h40;
    tick(); chk_all("boot_ignores_redir", 32'h0, 1, 0, 0);
    redirect_addr = 32'hFFFF_FFFC;
    tick(); chk_all("redir_top", 32'hFFFF_FFFC, 1, 0, 0);
    redirect_valid = 0; pc_ready = 1; resume = 1;
    tick(); chk_all("wrap", 32'h0, 1, 0, 0);
    resume = 0;
    tick(); chk_all("after_wrap", 32'h4, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
